exc_request_arbiter: RTL
========================

Name: exc_request_arbiter

Overview:
- Sits directly upstream of the CP0 register file.
- Collects synchronous exception requests (syscall, break, teq trap) from decode/execute and external interrupt lines.
- Qualifies the requests against the CP0 status word, prioritises them, and drives CP0's exc_signal, cause and pc inputs, plus a pipeline flush.
- Tracks handler residency so that nested entries are never issued and eret is only forwarded while a handler is active.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8), mapped to status[8+i].
- CNT_W, 16, width of the saturating taken-exception counter.

Ports:
- clock_in  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- syscall_req  input  1  syscall in execute this cycle.
- break_req  input  1  break in execute this cycle.
- teq_req  input  1  teq condition true in execute this cycle.
- irq  input  NUM_IRQ  level-sensitive external interrupts.
- eret_req  input  1  eret in execute this cycle.
- status  input  32  CP0 status word (CP0 data_out[63:32]).
- pc_in  input  32  pc of the instruction in execute.
- exc_signal  output  2  to CP0: [1]=enter pulse, [0]=return pulse.
- cause  output  4  to CP0: exception code.
- exc_pc  output  32  to CP0 pc input: epc value.
- flush  output  1  kill younger pipeline stages.
- in_handler  output  1  high while a handler is active.
- lost_req  output  1  sticky: a request arrived while in_handler.
- exc_count  output  CNT_W  number of entries taken, saturating.

Behaviour:
- Reset (async) values:
  - exc_signal=0, cause=0, exc_pc=0, flush=0, in_handler=0, lost_req=0, exc_count=0.
  - State=IDLE.
- Qualification:
  - status[0]=global IE.
  - teq enabled by status[3], break by status[2], syscall by status[1].
  - irq[i] enabled by status[8+i].
  - Nothing is taken when IE=0.
- Priority, highest first: teq (cause 4'hD) > break (4'h9) > syscall (4'h8) > any irq (4'h0).
- Outputs are registered: a request sampled at posedge N appears at posedge N+1 and is held for exactly one cycle. CP0 consumes on the following negedge.
- States:
  - IDLE: if any qualified request, go to ENTER. Latch cause and pc, where exc_pc=pc_in for sync exceptions and pc_in+4 for irq. Otherwise, eret_req is ignored (no pulse).
  - ENTER (1 cycle): exc_signal=2'b10, flush=1. exc_count increments unless all-ones. Go to HANDLER.
  - HANDLER: in_handler=1.
    - eret_req goes to RETURN.
    - Any qualified or unqualified sync request, or qualified irq, without eret sets lost_req and is not serviced.
  - RETURN (1 cycle): exc_signal=2'b01, flush=1, in_handler=1. Clears lost_req. Go to IDLE.
- Simultaneous events:
  - eret_req and an exception in HANDLER: eret wins, lost_req is set, and RETURN still clears it at exit. Net effect: lost_req is 0 after RETURN.
  - Multiple requests in IDLE: only the highest priority is taken. The others are not remembered; sync sources re-raise after restart, irq remains level.
- exc_signal is never 2'b11. The enter and return pulses are never back-to-back; at least one HANDLER cycle separates them.
- The status value is sampled only in IDLE; changes during HANDLER have no effect until return.
- Reset asserted mid-ENTER/HANDLER/RETURN: immediate return to the reset values; no partial pulse.
- cause/exc_pc hold their last value outside ENTER.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: each irq bit passes through a two-flop synchroniser clocked on clock_in and reset by reset. irq-to-ENTER latency becomes 3 cycles.
- Undefined: irq is used directly, latency 1 cycle. The irq inputs must then already be synchronous to clock_in.

Test Plan:
- Syscall: reset, status=32'h0000000F, pc_in=32'h00400100, syscall_req for 1 cycle -> next cycle exc_signal=2'b10, cause=4'h8, exc_pc=32'h00400100, flush=1, exc_count=1, then in_handler=1.
- Priority: teq_req+break_req+syscall_req together with IE=1 -> cause=4'hD only, single enter pulse.
- Masking: status=32'h0000000E, syscall_req -> no pulse, state IDLE. Then status=32'h00000101, irq[0]=1, pc_in=32'h00400200 -> cause=4'h0, exc_pc=32'h00400204.
- Nesting: in HANDLER, syscall_req -> no exc_signal, lost_req=1. Then eret_req -> exc_signal=2'b01 one cycle, lost_req=0, in_handler=0 afterwards.
- Stray eret: eret_req in IDLE -> exc_signal stays 2'b00.
- Reset mid-handler: assert reset asynchronously in HANDLER -> all outputs 0 immediately, next syscall taken normally. With IRQ_SYNC_EN, irq-to-pulse latency measured as 3 cycles.

Source files
------------

// File: rtl/exc_request_arbiter.sv
// ============================================================================
// Module   : exc_request_arbiter
// Purpose  : Qualifies, prioritises and sequences exception entry/return
//            requests toward the CP0 register file. Optional macro
//            IRQ_SYNC_EN adds a two-flop synchroniser on each irq line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_request_arbiter #(
    parameter int NUM_IRQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               syscall_req,
    input  logic               break_req,
    input  logic               teq_req,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               eret_req,
    input  logic [31:0]        status,
    input  logic [31:0]        pc_in,
    output logic [1:0]         exc_signal,
    output logic [3:0]         cause,
    output logic [31:0]        exc_pc,
    output logic               flush,
    output logic               in_handler,
    output logic               lost_req,
    output logic [CNT_W-1:0]   exc_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTER   = 2'd1,
        S_HANDLER = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    localparam logic [3:0] C_CAUSE_TEQ   = 4'hD;
    localparam logic [3:0] C_CAUSE_BREAK = 4'h9;
    localparam logic [3:0] C_CAUSE_SYS   = 4'h8;
    localparam logic [3:0] C_CAUSE_IRQ   = 4'h0;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irq_mask;
    logic [NUM_IRQ-1:0] w_irq;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_irq_s1;
    logic [NUM_IRQ-1:0] r_irq_s2;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_irq_s1 <= '0;
            r_irq_s2 <= '0;
        end else begin
            r_irq_s1 <= irq;
            r_irq_s2 <= r_irq_s1;
        end
    end

    assign w_irq = r_irq_s2;
`else
    assign w_irq = irq;
`endif

    logic               w_ie;
    logic               w_teq_q;
    logic               w_break_q;
    logic               w_sys_q;
    logic [NUM_IRQ-1:0] w_irq_en;
    logic               w_irq_q;
    logic               w_take;
    logic               w_lost_evt;
    logic               w_unused_status;

    assign w_ie      = status[0];
    assign w_teq_q   = w_ie & status[3] & teq_req;
    assign w_break_q = w_ie & status[2] & break_req;
    assign w_sys_q   = w_ie & status[1] & syscall_req;
    assign w_irq_en  = status[8 +: NUM_IRQ] & {NUM_IRQ{w_ie}};
    assign w_irq_q   = |(w_irq & w_irq_en);
    assign w_take    = w_teq_q | w_break_q | w_sys_q | w_irq_q;

    // Inside a handler the irq mask is the one captured while idle, so status
    // writes by the handler cannot alter what counts as a lost request.
    assign w_lost_evt = syscall_req | break_req | teq_req | (|(w_irq & r_irq_mask));

    assign w_unused_status = ^{status[31:8+NUM_IRQ], status[7:4]};

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_irq_mask <= '0;
            exc_signal <= 2'b00;
            cause      <= 4'h0;
            exc_pc     <= 32'h0;
            flush      <= 1'b0;
            in_handler <= 1'b0;
            lost_req   <= 1'b0;
            exc_count  <= '0;
        end else begin
            exc_signal <= 2'b00;
            flush      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_irq_mask <= w_irq_en;
                    if (w_take) begin
                        r_state    <= S_ENTER;
                        exc_signal <= 2'b10;
                        flush      <= 1'b1;
                        if (exc_count != {CNT_W{1'b1}}) begin
                            exc_count <= exc_count + CNT_W'(1);
                        end
                        if (w_teq_q) begin
                            cause  <= C_CAUSE_TEQ;
                            exc_pc <= pc_in;
                        end else if (w_break_q) begin
                            cause  <= C_CAUSE_BREAK;
                            exc_pc <= pc_in;
                        end else if (w_sys_q) begin
                            cause  <= C_CAUSE_SYS;
                            exc_pc <= pc_in;
                        end else begin
                            // Interrupts resume after the interrupted instruction.
                            cause  <= C_CAUSE_IRQ;
                            exc_pc <= pc_in + 32'd4;
                        end
                    end
                end
                S_ENTER: begin
                    r_state    <= S_HANDLER;
                    in_handler <= 1'b1;
                end
                S_HANDLER: begin
                    if (w_lost_evt) begin
                        lost_req <= 1'b1;
                    end
                    if (eret_req) begin
                        r_state    <= S_RETURN;
                        exc_signal <= 2'b01;
                        flush      <= 1'b1;
                    end
                end
                S_RETURN: begin
                    r_state    <= S_IDLE;
                    in_handler <= 1'b0;
                    lost_req   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
